// File: rtl/relu_maxpool_stream_if.sv
// Valid/ready sample stream between convolution, pooling and downstream stages.
//   data  : signed sample, WIDTH bits
//   valid : producer has a sample this cycle
//   ready : consumer accepts the sample this cycle
// master = producer side, slave = consumer side.
interface relu_maxpool_stream_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] data;
  logic                    valid;
  logic                    ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU + non-overlapping 1-D max-pool stage.
// Every POOL consecutive samples of a LENY-sample vector reduce to their signed
// maximum (the last window of a vector may be shorter); negatives optionally
// clamp to zero. One result register with valid/ready handshake on the output.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   s_y   : input sample stream (slave)  - data/valid in, ready out
//   m_z   : pooled result stream (master) - data/valid out (registered), ready in
module relu_maxpool_stream #(
  parameter int WIDTH  = 16,
  parameter int LENY   = 15,
  parameter int POOL   = 3,
  parameter int RELU   = 1,
  parameter int LOGLEN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  relu_maxpool_stream_if.slave  s_y,
  relu_maxpool_stream_if.master m_z
);

  logic [LOGLEN-1:0]       elem_cnt;
  logic [LOGLEN-1:0]       win_cnt;
  logic signed [WIDTH-1:0] acc;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_valid;

  logic                    in_xfer;
  logic                    out_xfer;
  logic                    last_elem;
  logic                    win_first;
  logic                    win_close;
  logic signed [WIDTH-1:0] cand;
  logic signed [WIDTH-1:0] result;

  // Ready is held low during reset; otherwise accept whenever the result
  // register is empty or draining this cycle.
  assign s_y.ready = reset ? (!out_valid || m_z.ready) : 1'b0;
  assign m_z.data  = out_data;
  assign m_z.valid = out_valid;

  assign in_xfer   = s_y.valid && s_y.ready;
  assign out_xfer  = out_valid && m_z.ready;
  assign last_elem = (elem_cnt == LOGLEN'(LENY - 1));
  assign win_first = (win_cnt == '0);
  // The final window of a vector closes early when LENY is not a multiple of POOL.
  assign win_close = in_xfer && ((win_cnt == LOGLEN'(POOL - 1)) || last_elem);

  always_comb begin
    cand   = s_y.data;
    result = '0;
    if (!win_first && (acc > s_y.data)) begin
      cand = acc;
    end
    if ((RELU != 0) && cand[WIDTH-1]) begin
      result = '0;
    end else begin
      result = cand;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_cnt <= '0;
      win_cnt  <= '0;
      acc      <= '0;
    end else if (in_xfer) begin
      acc      <= cand;
      elem_cnt <= last_elem ? '0 : elem_cnt + 1'b1;
      win_cnt  <= win_close ? '0 : win_cnt + 1'b1;
    end
  end

  // A closing window in the same cycle as a drain reloads the register
  // instead of clearing it, keeping full throughput.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (win_close) begin
      out_data  <= result;
      out_valid <= 1'b1;
    end else if (out_xfer) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Self-checking bench for relu_maxpool_stream.
// dut_a: defaults (RELU=1); dut_b: RELU=0 mirroring dut_a's stream;
// dut_c: LENY=7, POOL=3 for the partial-window case.
module tb_relu_maxpool_stream;

  localparam int LENY_A = 15;
  localparam int POOL_A = 3;

  logic clk;
  logic reset;

  relu_maxpool_stream_if #(.WIDTH(16)) a_y ();
  relu_maxpool_stream_if #(.WIDTH(16)) a_z ();
  relu_maxpool_stream_if #(.WIDTH(16)) b_y ();
  relu_maxpool_stream_if #(.WIDTH(16)) b_z ();
  relu_maxpool_stream_if #(.WIDTH(16)) c_y ();
  relu_maxpool_stream_if #(.WIDTH(16)) c_z ();

  relu_maxpool_stream #(.WIDTH(16), .LENY(15), .POOL(3), .RELU(1), .LOGLEN(4)) dut_a (
    .clk(clk), .reset(reset), .s_y(a_y), .m_z(a_z));
  relu_maxpool_stream #(.WIDTH(16), .LENY(15), .POOL(3), .RELU(0), .LOGLEN(4)) dut_b (
    .clk(clk), .reset(reset), .s_y(b_y), .m_z(b_z));
  relu_maxpool_stream #(.WIDTH(16), .LENY(7), .POOL(3), .RELU(1), .LOGLEN(3)) dut_c (
    .clk(clk), .reset(reset), .s_y(c_y), .m_z(c_z));

  assign b_y.data  = a_y.data;
  assign b_y.valid = a_y.valid;
  assign b_z.ready = a_z.ready;

  int checks   = 0;
  int failures = 0;

  int obs_a[$];
  int obs_b[$];
  int obs_c[$];
  int exp_a[$];
  int exp_b[$];
  int cur_vec[$];

  bit hold_low  = 1'b0;
  bit rand_rdy  = 1'b0;
  bit watch_rdy = 1'b0;
  int rdy_low_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: collect a full vector, then max over each POOL-sized slice.
  task automatic model_push(input int x);
    cur_vec.push_back(x);
    if (cur_vec.size() == LENY_A) begin
      for (int s = 0; s < LENY_A; s += POOL_A) begin
        int m;
        m = cur_vec[s];
        for (int k = s + 1; k < s + POOL_A && k < LENY_A; k++)
          if (cur_vec[k] > m) m = cur_vec[k];
        exp_b.push_back(m);
        exp_a.push_back(m < 0 ? 0 : m);
      end
      cur_vec.delete();
    end
  endtask

  task automatic flush();
    obs_a.delete(); obs_b.delete(); obs_c.delete();
    exp_a.delete(); exp_b.delete(); cur_vec.delete();
  endtask

  task automatic compare_q(input string tag, input int obs[$], input int exp[$]);
    check({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++)
      check($sformatf("%s[%0d]", tag, i), obs[i], exp[i]);
  endtask

  function automatic int rnd_sample();
    int r;
    r = int'($urandom % 8);
    if (r == 0) return -32768;
    if (r == 1) return 32767;
    return int'($signed(16'($urandom)));
  endfunction

  // Monitors sample mid-cycle; a handshake seen here completes at the next edge.
  initial forever begin
    @(negedge clk);
    if (reset && a_y.valid && a_y.ready) model_push(int'(a_y.data));
    if (a_z.valid && a_z.ready) obs_a.push_back(int'(a_z.data));
    if (b_z.valid && b_z.ready) obs_b.push_back(int'(b_z.data));
    if (c_z.valid && c_z.ready) obs_c.push_back(int'(c_z.data));
    if (watch_rdy && reset && !a_y.ready) rdy_low_cnt++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    a_z.ready = hold_low ? 1'b0 : (rand_rdy ? 1'($urandom % 2) : 1'b1);
  end

  // Present samples to dut_a (and mirrored dut_b); called at posedge+1.
  task automatic send_a(input int v[$], input bit rv);
    int idx;
    int budget;
    bit took;
    idx = 0;
    budget = 0;
    while (idx < v.size() && budget < 5000) begin
      a_y.valid = rv ? 1'($urandom % 2) : 1'b1;
      a_y.data  = 16'(v[idx]);
      @(negedge clk);
      took = a_y.valid && a_y.ready;
      @(posedge clk);
      #1;
      if (took) idx++;
      budget++;
    end
    a_y.valid = 1'b0;
    check("feed_done", idx, v.size());
  endtask

  task automatic drain();
    rand_rdy = 1'b0;
    hold_low = 1'b0;
    tick(10);
  endtask

  int dvec[$] = '{-58, 10, 3, 7, -2, 100, -32768, -1, -5, 32767, 0, 1, 4, 4, -4};
  int dexp_a[$] = '{10, 100, 0, 32767, 4};
  int dexp_b[$] = '{10, 100, -1, 32767, 4};
  int cexp[$] = '{3, 9, 0};

  initial begin
    int rv[$];
    int cvec[$];
    bit seen;
    reset = 1'b0;
    a_y.valid = 1'b0; a_y.data = '0;
    c_y.valid = 1'b0; c_y.data = '0; c_z.ready = 1'b1;
    tick(3);
    check("rst_valid", int'(a_z.valid), 0);
    check("rst_data", int'(a_z.data), 0);
    check("rst_ready", int'(a_y.ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", int'(a_y.ready), 1);
    tick(1);

    // Directed vector, continuous handshake.
    flush();
    watch_rdy = 1'b1;
    send_a(dvec, 1'b0);
    watch_rdy = 1'b0;
    drain();
    check("rdy_stayed_high", rdy_low_cnt, 0);
    compare_q("dir_relu", obs_a, dexp_a);
    compare_q("dir_norelu", obs_b, dexp_b);

    // Backpressure: output stalled right after the first window closes.
    flush();
    hold_low = 1'b1;
    tick(1);
    fork
      send_a(dvec, 1'b0);
      begin
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge clk);
          seen = a_z.valid;
        end
        check("bp_first_valid", int'(seen), 1);
        for (int t = 0; t < 10; t++) begin
          @(negedge clk);
          check("bp_hold_data", int'(a_z.data), 10);
          check("bp_hold_valid", int'(a_z.valid), 1);
          check("bp_in_ready", int'(a_y.ready), 0);
        end
        hold_low = 1'b0;
      end
    join
    drain();
    compare_q("bp_relu", obs_a, dexp_a);

    // Random valid/ready, 20 vectors against the reference.
    flush();
    rv.delete();
    for (int i = 0; i < 20 * LENY_A; i++) rv.push_back(rnd_sample());
    rand_rdy = 1'b1;
    send_a(rv, 1'b1);
    drain();
    compare_q("rnd_relu", obs_a, exp_a);
    compare_q("rnd_norelu", obs_b, exp_b);
    check("rnd_total", obs_a.size(), 100);

    // Reset in the middle of a vector.
    flush();
    rv.delete();
    for (int i = 0; i < 4; i++) rv.push_back(dvec[i]);
    send_a(rv, 1'b0);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", int'(a_z.valid), 0);
    check("mid_rst_data", int'(a_z.data), 0);
    check("mid_rst_ready", int'(a_y.ready), 0);
    tick(2);
    reset = 1'b1;
    flush();
    rv.delete();
    for (int i = 0; i < LENY_A; i++) rv.push_back(rnd_sample());
    send_a(rv, 1'b0);
    drain();
    compare_q("post_rst_relu", obs_a, exp_a);
    compare_q("post_rst_norelu", obs_b, exp_b);

    // LENY=7 instance: trailing single-sample window.
    flush();
    cvec = '{1, 2, 3, 9, 8, 7, -6};
    for (int i = 0; i < 7; i++) begin
      c_y.valid = 1'b1;
      c_y.data  = 16'(cvec[i]);
      @(negedge clk);
      check($sformatf("c_ready[%0d]", i), int'(c_y.ready), 1);
      tick(1);
    end
    c_y.valid = 1'b0;
    check("c_last_valid", int'(c_z.valid), 1);
    check("c_last_data", int'(c_z.data), 0);
    tick(3);
    compare_q("c_out", obs_c, cexp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_stream.md
# relu_maxpool_stream

Streaming ReLU + 1-D max-pool stage placed directly downstream of a convolution layer (e.g. the 24-input / 10-tap / P=3 layer producing 15 outputs per vector). It consumes the layer's `m_data_out_y` / `m_valid_y` / `m_ready_y` stream. It reduces every non-overlapping window of `POOL` consecutive samples to its signed maximum and optionally clamps negatives to zero. Results are emitted on a single-entry registered valid/ready output that can feed the next layer's `s_data_in_x` port.

## Interface
- `WIDTH`, 16: sample width, signed two's complement.
- `LENY`, 15: samples per input vector (= LENX - LENF + 1 of the upstream layer).
- `POOL`, 3: window size and stride; 1 ≤ POOL ≤ LENY.
- `RELU`, 1: 1 = clamp negative results to 0; 0 = pass the signed maximum.
- `LOGLEN`, 4: counter width; 2^LOGLEN ≥ LENY.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `s_data_in_y`  in  WIDTH  signed input sample from the conv stage.
- `s_valid_y`  in  1  input sample valid.
- `s_ready_y`  out  1  block can accept a sample this cycle.
- `m_data_out_z`  out  WIDTH  pooled (and ReLU'd) result, registered.
- `m_valid_z`  out  1  result valid, registered.
- `m_ready_z`  in  1  downstream accepts the result.

## Operation
- Input transfer: `s_valid_y && s_ready_y` on a rising edge. Output transfer: `m_valid_z && m_ready_z`.
- Counters:
  - `elem_cnt` counts 0..LENY-1 within the vector.
  - `win_cnt` counts 0..POOL-1 within the window.
  - Both advance only on an input transfer.
  - `win_cnt` wraps to 0 after POOL-1 and at the last vector element.
  - `elem_cnt` wraps to 0 after LENY-1.
- Running max register `acc`:
  - On an input transfer with win_cnt==0, `acc` loads x.
  - Otherwise `acc` loads max(acc, x), using a signed compare.
  - On equal values, either value is acceptable (the results are identical).
- Window close: an input transfer where `win_cnt==POOL-1` or `elem_cnt==LENY-1`.
  - The candidate c = (win_cnt==0 ? x : max(acc,x)) is computed.
  - `m_data_out_z` loads (RELU && c<0) ? 0 : c.
  - `m_valid_z` is set to 1.
- Partial window: when LENY mod POOL ≠ 0, the final window of each vector holds LENY mod POOL samples and is still emitted.
  - Outputs per vector = ceil(LENY/POOL); 5 for the defaults.
- Output register:
  - Cleared by an output transfer, unless a window closes in the same cycle; in that case it reloads and stays at 1.
  - While `m_valid_z && !m_ready_z`, `m_data_out_z` and `m_valid_z` are held stable.
- Flow control: `s_ready_y = reset_n_active ? 0 : (!m_valid_z || m_ready_z)`.
  - This is combinational from `m_ready_z` and the output register.
  - Input is stalled whenever the output register is full and not draining, including mid-window (simple, conservative).
- No arithmetic growth: the max and the ReLU stay at WIDTH bits; no saturation is needed. Extremes −32768 and 32767 pass unchanged (or −32768 → 0 with RELU=1).
- Vectors are back-to-back: after `elem_cnt` wraps, the next sample starts a new vector and a new window with no idle cycle.

## Timing
- Reset (`reset`=0, asynchronous): `m_valid_z`=0, `m_data_out_z`=0, `acc`=0, `elem_cnt`=0, `win_cnt`=0, `s_ready_y`=0.
- After reset deasserts, `s_ready_y`=1 from the first clock edge onward.
- Reset mid-vector discards the partial window and any pending output; the next accepted sample is element 0 of a new vector.
- Latency: `m_valid_z` rises on the same edge that accepts the window-closing sample, so it is visible in the following cycle.
- Throughput: 1 sample/cycle when `m_ready_z` is held 1. No bubbles at window or vector boundaries.
- Backpressure: with `m_ready_z`=0 and `m_valid_z`=1, `s_ready_y`=0. When `m_ready_z` rises, the input is accepted in the same cycle.

## Test plan
- Defaults, continuous valid/ready, input vector −58,10,3, 7,−2,100, −32768,−1,−5, 32767,0,1, 4,4,−4.
  - Required outputs: 10, 100, 0, 32767, 4.
  - Five output transfers total; `s_ready_y` stays 1 throughout.
- Same vector with RELU=0 → 10, 100, −1, 32767, 4.
- LENY=7, POOL=3, input 1,2,3,9,8,7,−6, RELU=1 → 3, 9, 0. The third output is a single-sample partial window and is emitted immediately after the 7th input.
- Defaults, `m_ready_z`=0 for 10 cycles after the first window closes:
  - `m_data_out_z`=10 is held.
  - `s_ready_y`=0 and no inputs are lost.
  - After release, the remaining outputs match the first scenario.
- Random `s_valid_y` and `m_ready_z` (50%), 20 consecutive vectors. The output stream must match a reference model exactly: 100 results in order, no duplicates or drops.
- Assert `reset` after 4 accepted samples of a vector.
  - All outputs return to their reset values.
  - A fresh 15-sample vector then yields exactly 5 correct results with no stale data.
